csc_matrix: RTL and testbench
=============================

# csc_matrix

Parametrised colour-space converter: a 3×3 signed fixed-point matrix plus per-channel offset, with rounding and saturation, applied to a streaming RGB pixel bus with HSync/VSync/LineValid/FrameValid. It is the generalised successor of the fixed-coefficient grayscale converter. It sits in the camera → VGA video path. Coefficients are runtime-writable through a shadow register bank and take effect only at a frame boundary.

## Interface
- DATA_W, 8, bits per colour component (in and out)
- COEF_W, 12, signed coefficient width
- FRAC, 9, fractional bits of coefficients (FRAC ≥ 1)
- iClk  in  1  pixel clock; all state on rising edge
- iRst_n  in  1  asynchronous, active-low reset
- iR, iG, iB  in  DATA_W each  unsigned input components
- iHSync, iVSync, iLineValid, iFrameValid  in  1 each  sync/qualifier lines
- iMode  in  2  per-pixel mode: 0 matrix, 1 gray, 2 bypass, 3 treated as 2
- iCoefWe  in  1  shadow-bank write strobe
- iCoefAddr  in  4  shadow address: 0–8 coefficients row-major (C00..C22), 9–11 offsets O0..O2, 12–15 ignored
- iCoefData  in  COEF_W  write data; offsets use the low DATA_W+1 bits, signed
- iCoefCommit  in  1  single-cycle request to load shadow → active
- oC0, oC1, oC2  out  DATA_W each  output components
- oHSync, oVSync, oLineValid, oFrameValid  out  1 each  sync lines delayed to match data
- oCommitPending  out  1  commit requested but not yet applied

## Operation
- Channel math, k = 0..2: acc_k = C_k0·R + C_k1·G + C_k2·B + (O_k << FRAC) + (1 << (FRAC−1)).
- Inputs are zero-extended to signed.
- Accumulator width: DATA_W + COEF_W + 3; it must never overflow for any input.
- Result: acc_k >>> FRAC (arithmetic shift), then clamped to [0, 2^DATA_W − 1].
- Modes:
  - Matrix: outputs are channels 0, 1, 2.
  - Gray: oC0 = oC1 = oC2 = channel 0.
  - Bypass: oC0/1/2 = R/G/B delayed by the pipeline latency.
- iMode is sampled with its pixel and travels down the pipeline, so mode changes take effect exactly on the next pixel.
- Reset values of the active and shadow banks (BT.601, FRAC = 9 scale):
  - Row 0: 153, 301, 58; offset 0.
  - Row 1: −86, −170, 256; offset 128.
  - Row 2: 256, −214, −42; offset 128.
  - At other FRAC values: round(value × 2^FRAC / 512).
- iCoefWe writes the shadow register only. A write to address 12–15 has no effect.
- Commit state machine:
  - IDLE → PENDING on iCoefCommit.
  - PENDING → IDLE on the first cycle with iFrameValid = 0. In that same cycle the whole shadow bank is copied to the active bank.
  - iCoefCommit while iFrameValid = 0 moves to PENDING; the copy happens on the following cycle.
  - A repeated commit while PENDING is absorbed.
  - Shadow writes made while PENDING are included in the copy if they land on or before the copy cycle.
  - A shadow write and the copy in the same cycle: the copy uses the pre-write shadow value; the new value stays in shadow.
- oCommitPending = 1 exactly in PENDING.
- Active coefficients never change while iFrameValid = 1, so no frame is ever processed with mixed coefficient sets.

## Timing
- Latency is a fixed 4 cycles for data and sync, in every mode:
  - S1: register inputs, mode and syncs; form the 9 products.
  - S2: row partial sums (2 products + offset/round, plus 1 product).
  - S3: final sum.
  - S4: shift, clamp, mode mux into output registers.
- Full throughput: one pixel per clock, no stalls, no backpressure.
- The sync lines pass through the same 4 registers and are not combinationally derived.
- Pixels are processed regardless of LineValid; blanking data passes through unchanged in meaning.
- Reset (asserted at any time, including mid-frame or mid-commit):
  - All pipeline registers and outputs go to 0 immediately.
  - Commit FSM goes to IDLE; both banks return to the defaults.
  - The first valid output appears 4 cycles after the first post-reset input.

## Test plan
- Defaults, gray mode, input (100,150,200) → 4 cycles later oC0 = oC1 = oC2 = 141; (255,255,255) → 255; (0,0,0) → 0.
- Matrix mode, input (255,0,0) → (76, 85, 255); Cr clamps from 255.5 down to 255. Sync lines replicate the input pattern shifted by exactly 4 cycles.
- Positive clamp: write addr 0 = 1024, commit with FrameValid = 0; input R = 200, gray mode → oC0 = 255. Negative clamp: write O1 = −200 (addr 10), commit; input (0,0,0), matrix mode → oC1 = 0.
- Deferred commit: during FrameValid = 1, write addr 1 = 0 and pulse commit.
  - oCommitPending stays high and outputs keep using 301 until FrameValid falls.
  - Pixels in the next frame use 0; pending clears in the copy cycle.
- Bypass with alternating mode per pixel (0, 2, 0, 2) → each output pixel matches its own mode, with no cross-pixel bleed.
- Assert iRst_n low mid-frame while commit is pending → outputs and oCommitPending are 0 asynchronously; after release, the default coefficients are in effect.

Source files
------------

// File: rtl/csc_matrix.sv
// Streaming 3x3 fixed-point colour-space converter with per-channel offset, rounding and clamping.
// Coefficients are staged in a shadow bank and copied to the active bank only outside FrameValid.
module csc_matrix #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 12,
    parameter int FRAC   = 9
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [DATA_W-1:0] iR,
    input  logic [DATA_W-1:0] iG,
    input  logic [DATA_W-1:0] iB,
    input  logic              iHSync,
    input  logic              iVSync,
    input  logic              iLineValid,
    input  logic              iFrameValid,
    input  logic [1:0]        iMode,
    input  logic              iCoefWe,
    input  logic [3:0]        iCoefAddr,
    input  logic [COEF_W-1:0] iCoefData,
    input  logic              iCoefCommit,
    output logic [DATA_W-1:0] oC0,
    output logic [DATA_W-1:0] oC1,
    output logic [DATA_W-1:0] oC2,
    output logic              oHSync,
    output logic              oVSync,
    output logic              oLineValid,
    output logic              oFrameValid,
    output logic              oCommitPending
);

    localparam int AW = DATA_W + COEF_W + 3;
    localparam int OW = DATA_W + 1;
    localparam logic signed [AW-1:0] MAX_V = AW'((1 << DATA_W) - 1);
    localparam logic signed [AW-1:0] HALF  = AW'(1 << (FRAC - 1));

    // BT.601 defaults are expressed at FRAC = 9 and rescaled with rounding.
    function automatic logic signed [COEF_W-1:0] scale_coef(input int v);
        int s;
        if (FRAC >= 9) s = v <<< (FRAC - 9);
        else           s = (v + (1 <<< (8 - FRAC))) >>> (9 - FRAC);
        return COEF_W'(s);
    endfunction

    function automatic int bt601(input int idx);
        case (idx)
            0: return 153;   1: return 301;   2: return 58;
            3: return -86;   4: return -170;  5: return 256;
            6: return 256;   7: return -214;  8: return -42;
            default: return 0;
        endcase
    endfunction

    function automatic logic signed [OW-1:0] def_off(input int k);
        return (k == 0) ? OW'(0) : OW'(128);
    endfunction

    typedef enum logic {ST_IDLE, ST_PENDING} state_t;

    state_t state_q, state_d;
    logic   copy;

    logic signed [COEF_W-1:0] coef_act_q [9];
    logic signed [COEF_W-1:0] coef_sh_q  [9];
    logic signed [OW-1:0]     off_act_q  [3];
    logic signed [OW-1:0]     off_sh_q   [3];

    always_comb begin
        state_d = state_q;
        copy    = 1'b0;
        case (state_q)
            ST_IDLE:    if (iCoefCommit) state_d = ST_PENDING;
            ST_PENDING: if (!iFrameValid) begin
                state_d = ST_IDLE;
                copy    = 1'b1;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Copy reads the shadow value from before any same-cycle write.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 9; i++) begin
                coef_sh_q[i]  <= scale_coef(bt601(i));
                coef_act_q[i] <= scale_coef(bt601(i));
            end
            for (int k = 0; k < 3; k++) begin
                off_sh_q[k]  <= def_off(k);
                off_act_q[k] <= def_off(k);
            end
        end else begin
            state_q <= state_d;
            if (copy) begin
                coef_act_q <= coef_sh_q;
                off_act_q  <= off_sh_q;
            end
            if (iCoefWe) begin
                for (int i = 0; i < 9; i++)
                    if (iCoefAddr == 4'(i)) coef_sh_q[i] <= $signed(iCoefData);
                for (int k = 0; k < 3; k++)
                    if (iCoefAddr == 4'(9 + k)) off_sh_q[k] <= $signed(iCoefData[OW-1:0]);
            end
        end
    end

    assign oCommitPending = (state_q == ST_PENDING);

    logic [DATA_W-1:0]        pix     [3];
    logic signed [AW-1:0]     prod_d  [9];
    logic signed [AW-1:0]     offr_d  [3];
    logic signed [AW-1:0]     prod_q  [9];
    logic signed [AW-1:0]     offr_q  [3];
    logic signed [AW-1:0]     part_a_q[3];
    logic signed [AW-1:0]     part_b_q[3];
    logic signed [AW-1:0]     acc_q   [3];
    logic signed [AW-1:0]     shr     [3];
    logic [DATA_W-1:0]        sat     [3];
    logic [3*DATA_W-1:0]      rgb1_q, rgb2_q, rgb3_q, out_d, out_q;
    logic [1:0]               mode1_q, mode2_q, mode3_q;
    logic [3:0]               sync1_q, sync2_q, sync3_q, sync4_q;

    assign pix[0] = iR;
    assign pix[1] = iG;
    assign pix[2] = iB;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_prod
            assign prod_d[gi] = $signed({{(AW-DATA_W){1'b0}}, pix[gi % 3]}) * AW'(coef_act_q[gi]);
        end
        // Offset and rounding term is captured in S1 so each pixel sees one coefficient set.
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign offr_d[gi] = (AW'(off_act_q[gi]) <<< FRAC) + HALF;
            assign shr[gi]    = acc_q[gi] >>> FRAC;
            assign sat[gi]    = shr[gi][AW-1]    ? '0 :
                                (shr[gi] > MAX_V) ? {DATA_W{1'b1}} : shr[gi][DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        out_d = rgb3_q;
        case (mode3_q)
            2'd0:    out_d = {sat[0], sat[1], sat[2]};
            2'd1:    out_d = {sat[0], sat[0], sat[0]};
            default: out_d = rgb3_q;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
            for (int k = 0; k < 3; k++) begin
                offr_q[k]   <= '0;
                part_a_q[k] <= '0;
                part_b_q[k] <= '0;
                acc_q[k]    <= '0;
            end
            rgb1_q  <= '0;  rgb2_q  <= '0;  rgb3_q  <= '0;  out_q   <= '0;
            mode1_q <= '0;  mode2_q <= '0;  mode3_q <= '0;
            sync1_q <= '0;  sync2_q <= '0;  sync3_q <= '0;  sync4_q <= '0;
        end else begin
            prod_q <= prod_d;
            offr_q <= offr_d;
            for (int k = 0; k < 3; k++) begin
                part_a_q[k] <= prod_q[3*k] + prod_q[3*k+1] + offr_q[k];
                part_b_q[k] <= prod_q[3*k+2];
                acc_q[k]    <= part_a_q[k] + part_b_q[k];
            end
            rgb1_q  <= {iR, iG, iB};
            rgb2_q  <= rgb1_q;
            rgb3_q  <= rgb2_q;
            out_q   <= out_d;
            mode1_q <= iMode;
            mode2_q <= mode1_q;
            mode3_q <= mode2_q;
            sync1_q <= {iHSync, iVSync, iLineValid, iFrameValid};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            sync4_q <= sync3_q;
        end
    end

    assign {oC0, oC1, oC2} = out_q;
    assign {oHSync, oVSync, oLineValid, oFrameValid} = sync4_q;

endmodule

// File: tb/tb_csc_matrix.sv
// Self-checking bench for csc_matrix: constant vectors, directed commit/reset sequences,
// and randomized traffic compared against an integer reference model with a 4-deep expectation queue.
module tb_csc_matrix;

    localparam int DW  = 8;
    localparam int CW  = 12;
    localparam int FR  = 9;
    localparam int ONE = 1 << FR;
    localparam int SFV = 1, SLV = 2, SVS = 4, SHS = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] r_i, g_i, b_i;
    logic          hs_i, vs_i, lv_i, fv_i;
    logic [1:0]    mode_i;
    logic          we_i;
    logic [3:0]    addr_i;
    logic [CW-1:0] data_i;
    logic          commit_i;
    logic [DW-1:0] oC0, oC1, oC2;
    logic          oHSync, oVSync, oLineValid, oFrameValid, oCommitPending;

    always #5 clk = ~clk;

    csc_matrix #(.DATA_W(DW), .COEF_W(CW), .FRAC(FR)) dut (
        .iClk(clk), .iRst_n(rst_n),
        .iR(r_i), .iG(g_i), .iB(b_i),
        .iHSync(hs_i), .iVSync(vs_i), .iLineValid(lv_i), .iFrameValid(fv_i),
        .iMode(mode_i), .iCoefWe(we_i), .iCoefAddr(addr_i), .iCoefData(data_i),
        .iCoefCommit(commit_i),
        .oC0(oC0), .oC1(oC1), .oC2(oC2),
        .oHSync(oHSync), .oVSync(oVSync), .oLineValid(oLineValid), .oFrameValid(oFrameValid),
        .oCommitPending(oCommitPending)
    );

    typedef struct { int c0; int c1; int c2; int sync; } exp_t;
    typedef struct { int r; int g; int b; int md; int e0; int e1; int e2; } vec_t;

    int   sh_c[9], ac_c[9], sh_o[3], ac_o[3];
    bit   pend;
    exp_t hist[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic int sext(input int v, input int w);
        int x;
        x = v & ((1 << w) - 1);
        if (x >= (1 << (w - 1))) x -= (1 << w);
        return x;
    endfunction

    function automatic void model_reset();
        exp_t z;
        sh_c = '{153, 301, 58, -86, -170, 256, 256, -214, -42};
        ac_c = sh_c;
        sh_o = '{0, 128, 128};
        ac_o = sh_o;
        pend = 1'b0;
        z = '{0, 0, 0, 0};
        hist.delete();
        repeat (3) hist.push_back(z);
    endfunction

    // Real-number rule: floor((sum + offset*2^F + 2^(F-1)) / 2^F), clamped to the pixel range.
    function automatic int ref_chan(input int k, input int r, input int g, input int b);
        int acc, q;
        acc = ac_c[3*k]*r + ac_c[3*k+1]*g + ac_c[3*k+2]*b + ac_o[k]*ONE + ONE/2;
        q = acc / ONE;
        if (acc < 0 && (acc % ONE) != 0) q -= 1;
        if (q < 0) q = 0;
        if (q > (1 << DW) - 1) q = (1 << DW) - 1;
        return q;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input int r, input int g, input int b, input int md, input int sync,
                         input bit we, input int addr, input int data, input bit commit);
        exp_t e;
        r_i = DW'(r); g_i = DW'(g); b_i = DW'(b);
        mode_i = 2'(md);
        {hs_i, vs_i, lv_i, fv_i} = 4'(sync);
        we_i = we; addr_i = 4'(addr); data_i = CW'(data); commit_i = commit;
        e.sync = sync & 15;
        if (md == 0) begin
            e.c0 = ref_chan(0, r, g, b); e.c1 = ref_chan(1, r, g, b); e.c2 = ref_chan(2, r, g, b);
        end else if (md == 1) begin
            e.c0 = ref_chan(0, r, g, b); e.c1 = e.c0; e.c2 = e.c0;
        end else begin
            e.c0 = r; e.c1 = g; e.c2 = b;
        end
        hist.push_back(e);
        if (pend && (sync & SFV) == 0) begin
            ac_c = sh_c;
            ac_o = sh_o;
            pend = 1'b0;
        end else if (!pend && commit) begin
            pend = 1'b1;
        end
        if (we) begin
            if (addr < 9)       sh_c[addr]     = sext(data, CW);
            else if (addr < 12) sh_o[addr - 9] = sext(data, DW + 1);
        end
        @(posedge clk);
        #1;
        e = hist.pop_front();
        check("c0", int'(oC0), e.c0);
        check("c1", int'(oC1), e.c1);
        check("c2", int'(oC2), e.c2);
        check("sync", int'({oHSync, oVSync, oLineValid, oFrameValid}), e.sync);
        check("pending", int'(oCommitPending), int'(pend));
    endtask

    task automatic px(input int r, input int g, input int b, input int md, input int sync);
        cycle(r, g, b, md, sync, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic idle3(input int sync);
        repeat (3) px(0, 0, 0, 2, sync);
    endtask

    task automatic check_out(input string name, input int e0, input int e1, input int e2);
        check({name, "_c0"}, int'(oC0), e0);
        check({name, "_c1"}, int'(oC1), e1);
        check({name, "_c2"}, int'(oC2), e2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        bit   fv;
        int   sync;

        tbl[0] = '{100, 150, 200, 1, 141, 141, 141};
        tbl[1] = '{255, 255, 255, 1, 255, 255, 255};
        tbl[2] = '{0,   0,   0,   1, 0,   0,   0};
        tbl[3] = '{255, 0,   0,   0, 76,  85,  255};
        tbl[4] = '{12,  34,  56,  2, 12,  34,  56};

        rst_n = 1'b0;
        r_i = '0; g_i = '0; b_i = '0; mode_i = '0;
        {hs_i, vs_i, lv_i, fv_i} = '0;
        we_i = 1'b0; addr_i = '0; data_i = '0; commit_i = 1'b0;
        #12;
        check_out("reset", 0, 0, 0);
        check("reset_sync", int'({oHSync, oVSync, oLineValid, oFrameValid}), 0);
        check("reset_pend", int'(oCommitPending), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Constant vectors with default coefficients; sync pattern travels alongside.
        for (int i = 0; i < 5; i++) begin
            px(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].md, SFV | SLV | ((i & 1) != 0 ? SHS : SVS));
            idle3(0);
            check_out($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2);
        end

        // Positive clamp: C00 = 1024, commit outside a frame.
        cycle(0, 0, 0, 2, 0, 1'b1, 0, 1024, 1'b0);
        cycle(0, 0, 0, 2, 0, 1'b0, 0, 0, 1'b1);
        px(0, 0, 0, 2, 0);
        px(200, 0, 0, 1, SFV);
        idle3(SFV);
        check("clamp_hi", int'(oC0), 255);

        // Negative clamp: O1 = -200.
        cycle(0, 0, 0, 2, 0, 1'b1, 10, -200, 1'b0);
        cycle(0, 0, 0, 2, 0, 1'b0, 0, 0, 1'b1);
        px(0, 0, 0, 2, 0);
        px(0, 0, 0, 0, SFV);
        idle3(SFV);
        check("clamp_lo", int'(oC1), 0);

        // Asynchronous reset mid-frame while a commit is pending.
        cycle(9, 9, 9, 2, SFV | SLV, 1'b1, 0, 7, 1'b0);
        cycle(9, 9, 9, 2, SFV | SLV, 1'b0, 0, 0, 1'b1);
        repeat (4) px(9, 9, 9, 2, SFV | SLV);
        check("rst_pre_pend", int'(oCommitPending), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_async", 0, 0, 0);
        check("rst_async_sync", int'({oHSync, oVSync, oLineValid, oFrameValid}), 0);
        check("rst_async_pend", int'(oCommitPending), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        px(100, 150, 200, 1, SFV);
        idle3(SFV);
        check_out("rst_defaults", 141, 141, 141);

        // Deferred commit: C01 = 0 requested inside a frame.
        cycle(0, 100, 0, 1, SFV | SLV, 1'b1, 1, 0, 1'b0);
        cycle(0, 100, 0, 1, SFV | SLV, 1'b0, 0, 0, 1'b1);
        repeat (4) px(0, 100, 0, 1, SFV | SLV);
        check("defer_old", int'(oC0), 59);
        check("defer_pend", int'(oCommitPending), 1);
        px(0, 0, 0, 2, 0);
        check("defer_clear", int'(oCommitPending), 0);
        px(0, 100, 0, 1, SFV);
        idle3(SFV);
        check("defer_new", int'(oC0), 0);

        // Alternating matrix/bypass per pixel.
        px(255, 0, 0, 0, SFV);
        px(255, 0, 0, 2, SFV);
        px(255, 0, 0, 0, SFV);
        px(255, 0, 0, 2, SFV);
        check_out("alt0", 76, 85, 255);
        px(0, 0, 0, 2, SFV);
        check_out("alt1", 255, 0, 0);
        idle3(0);

        // Randomized traffic with coefficient writes and commits.
        fv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) fv = !fv;
            sync = int'($urandom_range(0, 7)) * 2 + int'(fv);
            cycle(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), sync,
                  ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 4095)), ($urandom_range(0, 24) == 0));
        end
        repeat (6) px(0, 0, 0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
